// File: rtl/mips_single_cycle.sv
// mips_single_cycle
//   Single-cycle 32-bit MIPS subset. Each instruction is fetched, decoded,
//   executed and retired in one clk period.
//   Supported: ADD/SUB/AND/OR/SLT (R-type), LW, SW, BEQ, J. Every other
//   opcode or funct executes as a NOP.
//   Instruction memory, register file and data memory sit in the named
//   blocks InstrMem, RegFile and DatMem. They are preloaded and observed
//   hierarchically; the block has no external buses.
// Ports
//   clk : single clock; pc, register-file writes and data-memory writes all
//         commit on its rising edge
//   rst : synchronous, active-low. While low, pc loads 0 and no register or
//         memory write occurs. Storage contents are never cleared.
module mips_single_cycle #(
  parameter int IMEM_BYTES = 256,
  parameter int DMEM_BYTES = 256
) (
  input logic clk,
  input logic rst
);

  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_BYTES);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  logic [31:0] pc_q, pc_d, pc, pc_plus4, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm;
  logic [31:0] rd1, rd2, alu_b, alu_res, dm_rdata, rfile_wd;
  logic [4:0]  rf_wa;
  logic        rf_we, dm_we;

  assign pc       = pc_q;
  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign sext_imm = {{16{instr[15]}}, instr[15:0]};

  // The shift-amount field has no use in this subset.
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  // Word-aligned little-endian fetch. The low pc bits are dropped and the
  // address wraps at IMEM_BYTES.
  if (1) begin : InstrMem
    logic [7:0] mem_array [0:IMEM_BYTES-1];
    assign instr = {mem_array[{pc[IAW-1:2], 2'b11}], mem_array[{pc[IAW-1:2], 2'b10}],
                    mem_array[{pc[IAW-1:2], 2'b01}], mem_array[{pc[IAW-1:2], 2'b00}]};
  end

  // Reads are combinational, so an instruction sees the value written by the
  // previous one with no forwarding logic. Register 0 is hard-wired to zero.
  if (1) begin : RegFile
    logic [31:0] file_array [0:31];
    assign rd1 = (rs == 5'd0) ? 32'd0 : file_array[rs];
    assign rd2 = (rt == 5'd0) ? 32'd0 : file_array[rt];
    always_ff @(posedge clk) begin
      if (rst && rf_we && rf_wa != 5'd0) file_array[rf_wa] <= rfile_wd;
    end
  end

  assign alu_b = (opcode == OP_RTYPE) ? rd2 : sext_imm;

  always_comb begin
    alu_res = rd1 + alu_b;
    rf_we   = 1'b0;
    rf_wa   = rd;
    dm_we   = 1'b0;
    pc_d    = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        rf_we = 1'b1;
        case (funct)
          FN_ADD:  alu_res = rd1 + alu_b;
          FN_SUB:  alu_res = rd1 - alu_b;
          FN_AND:  alu_res = rd1 & alu_b;
          FN_OR:   alu_res = rd1 | alu_b;
          FN_SLT:  alu_res = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
          default: rf_we   = 1'b0;
        endcase
      end
      OP_LW: begin
        rf_we = 1'b1;
        rf_wa = rt;
      end
      OP_SW:  dm_we = 1'b1;
      OP_BEQ: if (rd1 == rd2) pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
      OP_J:   pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  // Word-aligned little-endian access. The address wraps at DMEM_BYTES.
  if (1) begin : DatMem
    logic [7:0]     mem_array [0:DMEM_BYTES-1];
    logic [DAW-3:0] wa;
    assign wa       = alu_res[DAW-1:2];
    assign dm_rdata = {mem_array[{wa, 2'b11}], mem_array[{wa, 2'b10}],
                       mem_array[{wa, 2'b01}], mem_array[{wa, 2'b00}]};
    always_ff @(posedge clk) begin
      if (rst && dm_we) begin
        mem_array[{wa, 2'b00}] <= rd2[7:0];
        mem_array[{wa, 2'b01}] <= rd2[15:8];
        mem_array[{wa, 2'b10}] <= rd2[23:16];
        mem_array[{wa, 2'b11}] <= rd2[31:24];
      end
    end
  end

  assign rfile_wd = (opcode == OP_LW) ? dm_rdata : alu_res;

  always_ff @(posedge clk) begin
    if (!rst) pc_q <= 32'd0;
    else      pc_q <= pc_d;
  end

endmodule

// File: tb/tb_mips_single_cycle.sv
module tb_mips_single_cycle;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  mips_single_cycle #(.IMEM_BYTES(256), .DMEM_BYTES(256)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        chk_wd;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [0:17];

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction
  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {op[5:0], rs[4:0], rt[4:0], imm};
  endfunction

  task automatic set_imem(input int a, input logic [31:0] w);
    dut.InstrMem.mem_array[a]   = w[7:0];
    dut.InstrMem.mem_array[a+1] = w[15:8];
    dut.InstrMem.mem_array[a+2] = w[23:16];
    dut.InstrMem.mem_array[a+3] = w[31:24];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h00, 1'b1, 32'd8};
    vecs[1]  = '{32'h04, 1'b1, 32'd2};
    vecs[2]  = '{32'h08, 1'b1, 32'd1};
    vecs[3]  = '{32'h0C, 1'b1, 32'd7};
    vecs[4]  = '{32'h10, 1'b0, 32'd0};
    vecs[5]  = '{32'h14, 1'b1, 32'h12345678};
    vecs[6]  = '{32'h18, 1'b0, 32'd0};
    vecs[7]  = '{32'h1C, 1'b1, 32'd1};
    vecs[8]  = '{32'h20, 1'b0, 32'd0};
    vecs[9]  = '{32'h40, 1'b1, 32'd8};
    vecs[10] = '{32'h44, 1'b1, 32'd1};
    vecs[11] = '{32'h48, 1'b0, 32'd0};
    vecs[12] = '{32'h54, 1'b1, 32'hFFFFFFFE};
    vecs[13] = '{32'h58, 1'b1, 32'h12345678};
    vecs[14] = '{32'h5C, 1'b0, 32'd0};
    vecs[15] = '{32'h60, 1'b0, 32'd0};
    vecs[16] = '{32'h64, 1'b1, 32'h12345678};
    vecs[17] = '{32'h68, 1'b0, 32'd0};

    for (int i = 0; i < 256; i++) begin
      dut.InstrMem.mem_array[i] = 8'h00;
      dut.DatMem.mem_array[i]   = 8'h00;
    end
    for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = 32'd0;
    dut.RegFile.file_array[1]  = 32'd5;
    dut.RegFile.file_array[2]  = 32'd3;
    dut.RegFile.file_array[10] = 32'hFFFFFFFF;
    dut.RegFile.file_array[13] = 32'h0000DEAD;
    dut.RegFile.file_array[15] = 32'd8;
    dut.DatMem.mem_array[0] = 8'h78;
    dut.DatMem.mem_array[1] = 8'h56;
    dut.DatMem.mem_array[2] = 8'h34;
    dut.DatMem.mem_array[3] = 8'h12;

    set_imem(32'h00, rtype(1, 2, 3, 32));               // add $3,$1,$2
    set_imem(32'h04, rtype(1, 2, 4, 34));               // sub $4,$1,$2
    set_imem(32'h08, rtype(1, 2, 6, 36));               // and $6,$1,$2
    set_imem(32'h0C, rtype(1, 2, 7, 37));               // or  $7,$1,$2
    set_imem(32'h10, itype(4, 1, 2, 16'd2));            // beq $1,$2,+2 (not taken)
    set_imem(32'h14, itype(35, 0, 5, 16'd0));           // lw  $5,0($0)
    set_imem(32'h18, itype(43, 0, 5, 16'd4));           // sw  $5,4($0)
    set_imem(32'h1C, rtype(2, 1, 8, 42));               // slt $8,$2,$1
    set_imem(32'h20, {6'd2, 26'h0000010});              // j 0x10 -> 0x40
    set_imem(32'h40, rtype(1, 2, 0, 32));               // add $0,$1,$2
    set_imem(32'h44, rtype(10, 1, 9, 42));              // slt $9,$10,$1 (signed)
    set_imem(32'h48, itype(4, 1, 1, 16'd2));            // beq $1,$1,+2 -> 0x54
    set_imem(32'h54, rtype(2, 1, 11, 34));              // sub $11,$2,$1 (wraps)
    set_imem(32'h58, itype(35, 0, 12, 16'd2));          // lw  $12,2($0) (aligned down)
    set_imem(32'h5C, rtype(1, 2, 13, 63));              // undefined funct -> no write
    set_imem(32'h60, itype(63, 1, 13, 16'h1234));       // undefined opcode -> NOP
    set_imem(32'h64, itype(35, 15, 14, 16'hFFFC));      // lw  $14,-4($15)

    // Reset: one edge with rst low
    @(negedge clk);
    check("reset_pc", dut.pc, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      check($sformatf("pc_%0d", i), dut.pc, vecs[i].pc);
      if (vecs[i].chk_wd) check($sformatf("wd_%0d", i), dut.rfile_wd, vecs[i].wd);
      @(negedge clk);
    end

    check("r0_zero",  dut.RegFile.file_array[0],  32'd0);
    check("r3_add",   dut.RegFile.file_array[3],  32'd8);
    check("r4_sub",   dut.RegFile.file_array[4],  32'd2);
    check("r6_and",   dut.RegFile.file_array[6],  32'd1);
    check("r7_or",    dut.RegFile.file_array[7],  32'd7);
    check("r5_lw",    dut.RegFile.file_array[5],  32'h12345678);
    check("r8_slt",   dut.RegFile.file_array[8],  32'd1);
    check("r9_slts",  dut.RegFile.file_array[9],  32'd1);
    check("r11_wrap", dut.RegFile.file_array[11], 32'hFFFFFFFE);
    check("r12_lwal", dut.RegFile.file_array[12], 32'h12345678);
    check("r13_keep", dut.RegFile.file_array[13], 32'h0000DEAD);
    check("r14_lwneg", dut.RegFile.file_array[14], 32'h12345678);
    check("sw_word", {dut.DatMem.mem_array[7], dut.DatMem.mem_array[6],
                      dut.DatMem.mem_array[5], dut.DatMem.mem_array[4]}, 32'h12345678);

    // Mid-program reset: pending sw must not commit, pc returns to 0
    set_imem(32'h6C, itype(43, 0, 1, 16'd8));           // sw $1,8($0)
    check("pre_rst_pc", dut.pc, 32'h6C);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pc", dut.pc, 32'd0);
    check("midrst_nomem", {24'd0, dut.DatMem.mem_array[8]}, 32'd0);
    set_imem(32'h00, rtype(1, 2, 20, 32));              // add $20,$1,$2
    @(negedge clk);
    check("rst_hold_pc", dut.pc, 32'd0);
    check("rst_noreg", dut.RegFile.file_array[20], 32'd0);
    rst = 1'b1;
    check("rel_wd", dut.rfile_wd, 32'd8);
    @(negedge clk);
    check("rel_pc", dut.pc, 32'd4);
    check("rel_reg", dut.RegFile.file_array[20], 32'd8);

    // Taken branch at 0x10
    set_imem(32'h10, itype(4, 1, 1, 16'd2));            // beq $1,$1,+2
    repeat (3) @(negedge clk);
    check("beq_at", dut.pc, 32'h10);
    @(negedge clk);
    check("beq_taken", dut.pc, 32'h1C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
